// File: rtl/latq_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : latq_wr_pkg
// Description : Shared types, phase-length defaults and counter sizing helper
//               for the latq latch-bank write controller.
// Revision    : 1.0 - initial release
// ============================================================================
package latq_wr_pkg;

   // Write sequencing phases: D settles in SETUP, E is high in PULSE,
   // D is held in HOLD after E has fallen.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } wr_state_t;

   localparam int LATQ_WIDTH_DEF = 8;
   localparam int LATQ_DEPTH_DEF = 4;
   localparam int LATQ_ADDR_W_DEF = 2;
   localparam int LATQ_SETUP_CYC_DEF = 1;
   localparam int LATQ_PULSE_CYC_DEF = 1;
   localparam int LATQ_HOLD_CYC_DEF = 1;

   // The counter is loaded with (length-1), so clog2 of the longest phase
   // is enough; keep at least one bit so the vector is never zero-width.
   function automatic int cnt_width(input int setup_cyc,
                                    input int pulse_cyc,
                                    input int hold_cyc);
      int m;
      m = setup_cyc;
      if (pulse_cyc > m) m = pulse_cyc;
      if (hold_cyc > m) m = hold_cyc;
      if (m <= 1) return 1;
      return $clog2(m);
   endfunction

endpackage
`default_nettype wire

// File: rtl/latq_wr_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module      : latq_wr_phase_cnt
// Description : Loadable down-counter with zero flag; times each write phase.
// Revision    : 1.0 - initial release
// ============================================================================
module latq_wr_phase_cnt
   import latq_wr_pkg::*;
#(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // Load has priority; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/latq_bank_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : latq_bank_wr_ctrl
// Description : Write sequencer for a bank of level-sensitive latch rows.
//               Drives latch D/E from flops as setup -> enable -> hold and
//               keeps a flop shadow of the bank for readback.
// Revision    : 1.0 - initial release
// ============================================================================
module latq_bank_wr_ctrl
   import latq_wr_pkg::*;
#(
   parameter int WIDTH     = LATQ_WIDTH_DEF,
   parameter int DEPTH     = LATQ_DEPTH_DEF,
   parameter int ADDR_W    = LATQ_ADDR_W_DEF,
   parameter int SETUP_CYC = LATQ_SETUP_CYC_DEF,
   parameter int PULSE_CYC = LATQ_PULSE_CYC_DEF,
   parameter int HOLD_CYC  = LATQ_HOLD_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   output logic [WIDTH-1:0]  o_lat_d,
   output logic [DEPTH-1:0]  o_lat_e,
   output logic              o_busy,
   output logic              o_wr_done,
   output logic              o_wr_err,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   localparam int c_cnt_w = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
   localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYC - 1);
   localparam logic [c_cnt_w-1:0] c_pulse_ld = c_cnt_w'(PULSE_CYC - 1);
   localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(HOLD_CYC - 1);

   wr_state_t          r_state;
   logic [ADDR_W-1:0]  r_addr;
   logic [WIDTH-1:0]   r_lat_d;
   logic [DEPTH-1:0]   r_lat_e;
   logic               r_wr_done;
   logic               r_wr_err;
   logic [WIDTH-1:0]   r_shadow [DEPTH];

   logic               w_accept;
   logic               w_in_range;
   logic [DEPTH-1:0]   w_row_sel;
   logic               w_cnt_load;
   logic [c_cnt_w-1:0] w_cnt_val;
   logic               w_cnt_dec;
   logic               w_cnt_zero;

   assign o_wr_ready = (r_state == ST_IDLE) && !rst;
   assign w_accept   = i_wr_valid && o_wr_ready;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_lat_d    = r_lat_d;
   assign o_lat_e    = r_lat_e;
   assign o_wr_done  = r_wr_done;
   assign o_wr_err   = r_wr_err;

   // Row decode of the captured address; an out-of-range address selects no row.
   always_comb begin
      w_row_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_addr == ADDR_W'(i)) w_row_sel[i] = 1'b1;
      end
   end

   assign w_in_range = |w_row_sel;

   // Phase counter control: load on each phase entry, otherwise count down.
   always_comb begin
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;
      w_cnt_dec  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = c_setup_ld;
            end
         end
         ST_SETUP: begin
            if (w_cnt_zero) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = c_pulse_ld;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_PULSE: begin
            if (w_cnt_zero) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = c_hold_ld;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_HOLD: begin
            w_cnt_dec = 1'b1;
         end
         default: begin
            w_cnt_load = 1'b0;
         end
      endcase
   end

   latq_wr_phase_cnt #(
      .CNT_W (c_cnt_w)
   ) u_phase_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   // Write sequencer: D changes only on accept, E is raised only on entry to
   // PULSE (a cycle after D settled) and dropped on the edge leaving PULSE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_lat_d   <= '0;
         r_lat_e   <= '0;
         r_wr_done <= 1'b0;
         r_wr_err  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_shadow[i] <= '0;
      end else begin
         r_wr_done <= 1'b0;
         r_wr_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr  <= i_wr_addr;
                  r_lat_d <= i_wr_data;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_cnt_zero) begin
                  r_lat_e <= w_row_sel;
                  r_state <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (w_cnt_zero) begin
                  r_lat_e <= '0;
                  for (int i = 0; i < DEPTH; i++) begin
                     if (w_row_sel[i]) r_shadow[i] <= r_lat_d;
                  end
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_cnt_zero) begin
                  r_wr_done <= w_in_range;
                  r_wr_err  <= !w_in_range;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_lat_e <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Shadow readback; addresses beyond the bank read as zero.
   always_comb begin
      o_rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_rd_addr == ADDR_W'(i)) o_rd_data = r_shadow[i];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_latq_bank_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_latq_bank_wr_ctrl
// Description : Self-checking bench for latq_bank_wr_ctrl: default timing,
//               stretched phases and a 3-row bank, with a completion
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latq_bank_wr_ctrl;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;

   typedef struct {
      int         due;
      bit         err;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];

   // Default-parameter instance
   logic       da_valid, da_ready, da_busy, da_done, da_err;
   logic [1:0] da_addr, da_rd;
   logic [7:0] da_data, da_lat_d, da_rdd;
   logic [3:0] da_lat_e;

   // Stretched-phase instance (2/3/2)
   logic       dt_valid, dt_ready, dt_busy, dt_done, dt_err;
   logic [1:0] dt_addr, dt_rd;
   logic [7:0] dt_data, dt_lat_d, dt_rdd;
   logic [3:0] dt_lat_e;

   // Three-row instance
   logic       d3_valid, d3_ready, d3_busy, d3_done, d3_err;
   logic [1:0] d3_addr, d3_rd;
   logic [7:0] d3_data, d3_lat_d, d3_rdd;
   logic [2:0] d3_lat_e;

   latq_bank_wr_ctrl u_dut (
      .clk (clk), .rst (rst),
      .i_wr_valid (da_valid), .o_wr_ready (da_ready),
      .i_wr_addr (da_addr), .i_wr_data (da_data),
      .o_lat_d (da_lat_d), .o_lat_e (da_lat_e), .o_busy (da_busy),
      .o_wr_done (da_done), .o_wr_err (da_err),
      .i_rd_addr (da_rd), .o_rd_data (da_rdd)
   );

   latq_bank_wr_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut_t (
      .clk (clk), .rst (rst),
      .i_wr_valid (dt_valid), .o_wr_ready (dt_ready),
      .i_wr_addr (dt_addr), .i_wr_data (dt_data),
      .o_lat_d (dt_lat_d), .o_lat_e (dt_lat_e), .o_busy (dt_busy),
      .o_wr_done (dt_done), .o_wr_err (dt_err),
      .i_rd_addr (dt_rd), .o_rd_data (dt_rdd)
   );

   latq_bank_wr_ctrl #(.DEPTH(3)) u_dut_d3 (
      .clk (clk), .rst (rst),
      .i_wr_valid (d3_valid), .o_wr_ready (d3_ready),
      .i_wr_addr (d3_addr), .i_wr_data (d3_data),
      .o_lat_d (d3_lat_d), .o_lat_e (d3_lat_e), .o_busy (d3_busy),
      .o_wr_done (d3_done), .o_wr_err (d3_err),
      .i_rd_addr (d3_rd), .o_rd_data (d3_rdd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (da_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_during_rst got=%b exp=0", da_ready); end
      rst = 1'b0;
      #1;
      total++; if (da_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", da_ready); end
      total++; if (da_lat_e !== 4'b0) begin bad++; $display("FAIL reset_lat_e got=%b exp=0000", da_lat_e); end
      total++; if (da_lat_d !== 8'h00) begin bad++; $display("FAIL reset_lat_d got=%h exp=00", da_lat_d); end
      total++; if ({da_busy, da_done, da_err} !== 3'b000) begin bad++; $display("FAIL reset_flags busy/done/err got=%b exp=000", {da_busy, da_done, da_err}); end
      total++; if ({dt_ready, d3_ready} !== 2'b11) begin bad++; $display("FAIL reset_ready_others got=%b exp=11", {dt_ready, d3_ready}); end
      for (int a = 0; a < 4; a++) begin
         da_rd = 2'(a);
         #1;
         total++; if (da_rdd !== 8'h00) begin bad++; $display("FAIL reset_shadow addr=%0d got=%h exp=00", a, da_rdd); end
      end
   endtask

   task automatic test_basic();
      exp_t       e;
      logic [3:0] exp_e;
      tick();
      da_addr = 2'd2; da_data = 8'hA5; da_valid = 1'b1; da_rd = 2'd2;
      tick();
      da_valid = 1'b0;
      sb.push_back('{due: cyc + 3, err: 1'b0, data: 8'hA5});
      for (int k = 1; k <= 6; k++) begin
         exp_e = (k == 2) ? 4'b0100 : 4'b0000;
         total++; if (da_lat_d !== 8'hA5) begin bad++; $display("FAIL basic_lat_d k=%0d got=%h exp=a5", k, da_lat_d); end
         total++; if (da_lat_e !== exp_e) begin bad++; $display("FAIL basic_lat_e k=%0d got=%b exp=%b", k, da_lat_e, exp_e); end
         total++; if (da_rdd !== ((k >= 3) ? 8'hA5 : 8'h00)) begin bad++; $display("FAIL basic_rd k=%0d got=%h", k, da_rdd); end
         total++; if (da_busy !== (k <= 3)) begin bad++; $display("FAIL basic_busy k=%0d got=%b", k, da_busy); end
         total++; if (da_done !== (k == 4) || da_err !== 1'b0) begin bad++; $display("FAIL basic_done k=%0d got done=%b err=%b", k, da_done, da_err); end
         if (k == 4) begin
            total++; if (da_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_at_done got=%b exp=1", da_ready); end
         end
         if (da_done || da_err) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL basic_sb unexpected completion cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               if (cyc != e.due || da_err !== e.err || da_rdd !== e.data) begin
                  bad++; $display("FAIL basic_sb got cyc=%0d err=%b rd=%h exp cyc=%0d err=%b rd=%h", cyc, da_err, da_rdd, e.due, e.err, e.data);
               end
            end
         end
         tick();
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL basic_sb_left got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      exp_t       e;
      logic [3:0] exp_e;
      logic [7:0] exp_d;
      da_addr = 2'd1; da_data = 8'h11; da_valid = 1'b1; da_rd = 2'd1;
      tick();
      sb.push_back('{due: cyc + 3, err: 1'b0, data: 8'h11});
      da_addr = 2'd3; da_data = 8'h22;
      for (int k = 1; k <= 9; k++) begin
         exp_d = (k <= 4) ? 8'h11 : 8'h22;
         exp_e = (k == 2) ? 4'b0010 : ((k == 6) ? 4'b1000 : 4'b0000);
         total++; if (da_lat_d !== exp_d) begin bad++; $display("FAIL b2b_lat_d k=%0d got=%h exp=%h", k, da_lat_d, exp_d); end
         total++; if (da_lat_e !== exp_e) begin bad++; $display("FAIL b2b_lat_e k=%0d got=%b exp=%b", k, da_lat_e, exp_e); end
         total++; if (da_done !== (k == 4 || k == 8) || da_err !== 1'b0) begin bad++; $display("FAIL b2b_done k=%0d got done=%b err=%b", k, da_done, da_err); end
         if (da_done || da_err) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL b2b_sb unexpected completion cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               if (cyc != e.due || da_err !== e.err || da_rdd !== e.data) begin
                  bad++; $display("FAIL b2b_sb got cyc=%0d err=%b rd=%h exp cyc=%0d err=%b rd=%h", cyc, da_err, da_rdd, e.due, e.err, e.data);
               end
            end
         end
         if (k == 4) begin
            total++; if (da_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_done got=%b exp=1", da_ready); end
            sb.push_back('{due: cyc + 4, err: 1'b0, data: 8'h22});
            da_rd = 2'd3;
         end
         if (k == 5) da_valid = 1'b0;
         tick();
      end
      da_rd = 2'd2;
      #1;
      total++; if (da_rdd !== 8'hA5) begin bad++; $display("FAIL b2b_row2_kept got=%h exp=a5", da_rdd); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_sb_left got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      da_addr = 2'd0; da_data = 8'h77; da_valid = 1'b1; da_rd = 2'd0;
      tick();
      sb.push_back('{due: cyc + 3, err: 1'b0, data: 8'h77});
      for (int k = 1; k <= 6; k++) begin
         total++; if (da_lat_d !== 8'h77) begin bad++; $display("FAIL busy_lat_d k=%0d got=%h exp=77", k, da_lat_d); end
         total++; if (da_busy !== (k <= 3)) begin bad++; $display("FAIL busy_busy k=%0d got=%b", k, da_busy); end
         total++; if (da_done !== (k == 4)) begin bad++; $display("FAIL busy_done k=%0d got=%b", k, da_done); end
         if (da_done || da_err) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL busy_sb unexpected completion cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               if (cyc != e.due || da_err !== e.err || da_rdd !== e.data) begin
                  bad++; $display("FAIL busy_sb got cyc=%0d err=%b rd=%h exp cyc=%0d err=%b rd=%h", cyc, da_err, da_rdd, e.due, e.err, e.data);
               end
            end
         end
         if (k <= 3) begin
            da_addr = 2'd1;
            da_data = 8'(8'h80 + k);
         end else begin
            da_valid = 1'b0;
         end
         tick();
      end
      da_rd = 2'd1;
      #1;
      total++; if (da_rdd !== 8'h11) begin bad++; $display("FAIL busy_row1_kept got=%h exp=11", da_rdd); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL busy_sb_left got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_timing();
      exp_t       e;
      logic [3:0] exp_e;
      dt_addr = 2'd0; dt_data = 8'h3C; dt_valid = 1'b1; dt_rd = 2'd0;
      tick();
      dt_valid = 1'b0;
      sb.push_back('{due: cyc + 7, err: 1'b0, data: 8'h3C});
      for (int k = 1; k <= 10; k++) begin
         exp_e = (k >= 3 && k <= 5) ? 4'b0001 : 4'b0000;
         total++; if (dt_lat_d !== 8'h3C) begin bad++; $display("FAIL timing_lat_d k=%0d got=%h exp=3c", k, dt_lat_d); end
         total++; if (dt_lat_e !== exp_e) begin bad++; $display("FAIL timing_lat_e k=%0d got=%b exp=%b", k, dt_lat_e, exp_e); end
         total++; if (dt_done !== (k == 8) || dt_err !== 1'b0) begin bad++; $display("FAIL timing_done k=%0d got done=%b err=%b", k, dt_done, dt_err); end
         if (dt_done || dt_err) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL timing_sb unexpected completion cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               if (cyc != e.due || dt_err !== e.err || dt_rdd !== e.data) begin
                  bad++; $display("FAIL timing_sb got cyc=%0d err=%b rd=%h exp cyc=%0d err=%b rd=%h", cyc, dt_err, dt_rdd, e.due, e.err, e.data);
               end
            end
         end
         tick();
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL timing_sb_left got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_out_of_range();
      exp_t       e;
      logic [7:0] exp_rows [4];
      d3_addr = 2'd0; d3_data = 8'h99; d3_valid = 1'b1; d3_rd = 2'd0;
      tick();
      d3_valid = 1'b0;
      sb.push_back('{due: cyc + 3, err: 1'b0, data: 8'h99});
      for (int k = 1; k <= 4; k++) begin
         if (d3_done || d3_err) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL oor_pre_sb unexpected completion cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               if (cyc != e.due || d3_err !== e.err || d3_rdd !== e.data) begin
                  bad++; $display("FAIL oor_pre_sb got cyc=%0d err=%b rd=%h exp cyc=%0d err=%b rd=%h", cyc, d3_err, d3_rdd, e.due, e.err, e.data);
               end
            end
         end
         tick();
      end
      d3_addr = 2'd3; d3_data = 8'hFF; d3_valid = 1'b1;
      tick();
      d3_valid = 1'b0;
      sb.push_back('{due: cyc + 3, err: 1'b1, data: 8'h00});
      for (int k = 1; k <= 6; k++) begin
         total++; if (d3_lat_e !== 3'b000) begin bad++; $display("FAIL oor_lat_e k=%0d got=%b exp=000", k, d3_lat_e); end
         total++; if (d3_lat_d !== 8'hFF) begin bad++; $display("FAIL oor_lat_d k=%0d got=%h exp=ff", k, d3_lat_d); end
         total++; if (d3_err !== (k == 4) || d3_done !== 1'b0) begin bad++; $display("FAIL oor_err k=%0d got err=%b done=%b", k, d3_err, d3_done); end
         if (d3_done || d3_err) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL oor_sb unexpected completion cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               if (cyc != e.due || d3_err !== e.err) begin
                  bad++; $display("FAIL oor_sb got cyc=%0d err=%b exp cyc=%0d err=%b", cyc, d3_err, e.due, e.err);
               end
            end
         end
         tick();
      end
      exp_rows[0] = 8'h99; exp_rows[1] = 8'h00; exp_rows[2] = 8'h00; exp_rows[3] = 8'h00;
      for (int a = 0; a < 4; a++) begin
         d3_rd = 2'(a);
         #1;
         total++; if (d3_rdd !== exp_rows[a]) begin bad++; $display("FAIL oor_shadow addr=%0d got=%h exp=%h", a, d3_rdd, exp_rows[a]); end
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL oor_sb_left got=%0d exp=0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      tick();
      da_addr = 2'd1; da_data = 8'h5A; da_valid = 1'b1;
      tick();
      da_valid = 1'b0;
      sb.push_back('{due: cyc + 3, err: 1'b0, data: 8'h5A});
      tick();
      total++; if (da_lat_e !== 4'b0010) begin bad++; $display("FAIL rstmid_pulse got=%b exp=0010", da_lat_e); end
      rst = 1'b1;
      tick();
      sb.delete();
      total++; if (da_lat_e !== 4'b0000) begin bad++; $display("FAIL rstmid_lat_e got=%b exp=0000", da_lat_e); end
      total++; if ({da_done, da_err, da_busy, da_ready} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags done/err/busy/ready got=%b exp=0000", {da_done, da_err, da_busy, da_ready}); end
      rst = 1'b0;
      #1;
      total++; if (da_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", da_ready); end
      for (int a = 0; a < 4; a++) begin
         da_rd = 2'(a);
         #1;
         total++; if (da_rdd !== 8'h00) begin bad++; $display("FAIL rstmid_shadow addr=%0d got=%h exp=00", a, da_rdd); end
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         total++; if (da_done !== 1'b0 || da_err !== 1'b0 || da_lat_d !== 8'h00) begin bad++; $display("FAIL rstmid_quiet k=%0d got done=%b err=%b d=%h", k, da_done, da_err, da_lat_d); end
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL rstmid_sb_left got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      cyc = 0; total = 0; bad = 0;
      rst = 1'b1;
      da_valid = 1'b0; da_addr = '0; da_data = '0; da_rd = '0;
      dt_valid = 1'b0; dt_addr = '0; dt_data = '0; dt_rd = '0;
      d3_valid = 1'b0; d3_addr = '0; d3_data = '0; d3_rd = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_busy_ignore();
      test_timing();
      test_out_of_range();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
